// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer with one-shot and auto-reload modes.
// Drives one CP0 hardware interrupt line; CTRL/PRESET/COUNT window selected by addr.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t              state;
    logic [CTRL_W-1:0]   ctrl;
    logic [DATA_W-1:0]   preset;
    logic [DATA_W-1:0]   count;
    logic                irq_flag;

    logic ctrl_wr;
    logic preset_wr;
    logic en;
    logic im;
    logic auto_reload;

    assign ctrl_wr     = we && (addr == ADDR_CTRL);
    assign preset_wr   = we && (addr == ADDR_PRESET);
    assign en          = ctrl[0];
    assign im          = ctrl[3];
    // Only MODE=01 reloads; 1x falls back to one-shot.
    assign auto_reload = (ctrl[2:1] == 2'b01);

    // Register file and counting state machine.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl <= din[CTRL_W-1:0];
            end
            if (preset_wr) begin
                preset <= din;
            end
            if (ctrl_wr || preset_wr) begin
                irq_flag <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (count > DATA_W'(1)) begin
                        count <= count - DATA_W'(1);
                    end else begin
                        count <= '0;
                        state <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (auto_reload) begin
                        state <= ST_LOAD;
                    end else begin
                        // A same-cycle bus write to CTRL keeps its EN value; the flag set beats the clear.
                        if (!ctrl_wr) begin
                            ctrl[0] <= 1'b0;
                        end
                        irq_flag <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Level interrupt in one-shot, single-cycle pulse per period in auto-reload.
    always_comb begin
        irq = 1'b0;
        if (auto_reload) begin
            irq = (state == ST_INT) && im;
        end else begin
            irq = irq_flag && im;
        end
    end

    // Combinational read mux; unmapped word reads zero.
    always_comb begin
        dout = '0;
        case (addr)
            ADDR_CTRL:   dout = DATA_W'(ctrl);
            ADDR_PRESET: dout = preset;
            ADDR_COUNT:  dout = count;
            default:     dout = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: expected register/irq values are queued
// from the documented timing and popped when the DUT output is sampled.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int unsigned vectors;
    int unsigned miscompares;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        string       tag;
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            check(tag, got, exp);
        end
    endtask

    // Bus write landing on the next rising edge; returns just after that edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        sb_push(tag, exp);
        addr = a;
        #1;
        sb_pop(dout);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        sb_push(tag, 32'(exp));
        #1;
        sb_pop(32'(irq));
    endtask

    initial begin
        logic [31:0] d;
        vectors     = 0;
        miscompares = 0;
        reset = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        din   = '0;

        // Reset values
        #7;
        rd("rst_ctrl", 2'd0, 32'h0);
        rd("rst_preset", 2'd1, 32'h0);
        rd("rst_count", 2'd2, 32'h0);
        chk_irq("rst_irq", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick(1);

        // One-shot, PRESET=5
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick(1);
        rd("os_load_hold", 2'd2, 32'd0);
        tick(1);
        for (int j = 0; j < 6; j++) begin
            rd($sformatf("os_count%0d", j), 2'd2, 32'(5 - j));
            if (j < 5) tick(1);
        end
        chk_irq("os_irq_int", 1'b0);
        tick(1);
        chk_irq("os_irq_set", 1'b1);
        rd("os_ctrl_en_clr", 2'd0, 32'h8);
        tick(3);
        chk_irq("os_irq_hold", 1'b1);
        rd("os_count_stay", 2'd2, 32'd0);
        wr(2'd0, 32'h0);
        chk_irq("os_irq_clr", 1'b0);

        // Auto-reload, PRESET=3, IM=1 then IM=0
        for (int pass = 0; pass < 2; pass++) begin
            wr(2'd1, 32'd3);
            wr(2'd0, (pass == 0) ? 32'hB : 32'h3);
            for (int c = 1; c <= 16; c++) begin
                int p;
                tick(1);
                chk_irq($sformatf("ar%0d_irq_c%0d", pass, c),
                        (pass == 0) && (c >= 5) && ((c - 5) % 5 == 0));
                if (c >= 2) begin
                    p = (c - 2) % 5;
                    rd($sformatf("ar%0d_count_c%0d", pass, c), 2'd2, (p < 3) ? 32'(3 - p) : 32'd0);
                end
            end
            wr(2'd0, 32'h0);
            tick(3);
        end

        // Pause mid-count and restart from PRESET
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        tick(5);
        rd("pz_count7", 2'd2, 32'd7);
        wr(2'd0, 32'h8);
        for (int c = 0; c < 4; c++) begin
            rd($sformatf("pz_frozen%0d", c), 2'd2, 32'd6);
            tick(1);
        end
        chk_irq("pz_irq", 1'b0);
        wr(2'd0, 32'h9);
        tick(1);
        rd("pz_load_hold", 2'd2, 32'd6);
        tick(1);
        rd("pz_reload", 2'd2, 32'd10);
        wr(2'd0, 32'h0);
        tick(2);

        // PRESET rewritten mid-period in auto-reload
        wr(2'd1, 32'd4);
        wr(2'd0, 32'hB);
        tick(3);
        rd("mp_count3", 2'd2, 32'd3);
        wr(2'd1, 32'd2);
        rd("mp_cur2", 2'd2, 32'd2);
        tick(1);
        rd("mp_cur1", 2'd2, 32'd1);
        tick(1);
        rd("mp_cur0", 2'd2, 32'd0);
        chk_irq("mp_irq1", 1'b1);
        tick(1);
        chk_irq("mp_irq_off", 1'b0);
        tick(1);
        rd("mp_new2", 2'd2, 32'd2);
        tick(1);
        rd("mp_new1", 2'd2, 32'd1);
        tick(1);
        rd("mp_new0", 2'd2, 32'd0);
        chk_irq("mp_irq2", 1'b1);
        wr(2'd0, 32'h0);
        tick(3);

        // CTRL write colliding with the one-shot INT cycle
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        tick(4);
        rd("co_int_count", 2'd2, 32'd0);
        chk_irq("co_irq_pre", 1'b0);
        wr(2'd0, 32'h9);
        chk_irq("co_irq_set", 1'b1);
        rd("co_ctrl_kept", 2'd0, 32'h9);
        tick(2);
        rd("co_reload", 2'd2, 32'd2);
        chk_irq("co_irq_hold", 1'b1);
        tick(3);
        rd("co_ctrl_end", 2'd0, 32'h8);
        wr(2'd0, 32'h0);
        chk_irq("co_irq_clr", 1'b0);
        tick(2);

        // PRESET=0 acts like N=1; MODE=10 is one-shot; CTRL upper bits dropped
        wr(2'd1, 32'd0);
        d = 32'hFFFF_FFFD;
        wr(2'd0, d);
        rd("z_ctrl_mask", 2'd0, 32'hD);
        tick(3);
        rd("z_int_count", 2'd2, 32'd0);
        chk_irq("z_irq_int", 1'b0);
        tick(1);
        chk_irq("z_irq_set", 1'b1);
        rd("z_ctrl_after", 2'd0, 32'hC);

        // Asynchronous reset mid-count
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        tick(5);
        rd("ar_count7", 2'd2, 32'd7);
        #1;
        reset = 1'b0;
        rd("arst_count", 2'd2, 32'd0);
        rd("arst_ctrl", 2'd0, 32'd0);
        rd("arst_addr3", 2'd3, 32'd0);
        chk_irq("arst_irq", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick(4);
        rd("post_count", 2'd2, 32'd0);
        rd("post_preset", 2'd1, 32'd0);
        wr(2'd2, 32'h1234);
        wr(2'd3, 32'h5678);
        rd("ro_count", 2'd2, 32'd0);
        rd("ro_addr3", 2'd3, 32'd0);
        rd("ro_ctrl", 2'd0, 32'd0);

        if (exp_q.size() != 0) begin
            check("sb_leftover", 32'(exp_q.size()), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
